writeback_arbiter: RTL and testbench
====================================

# writeback_arbiter

- Merges the ALU result stream and the memory load-result stream into a single arbitrated write per cycle into the 1024 x 32 register/memory array.
- Each source has its own small FIFO with a valid/ready handshake.
- Grants alternate round-robin, and the winning entry is driven as a registered write strobe.
- An optional key check drops writes whose key does not match the array's `key_access` value.

## Interface
- `ADDR_W`, 10, write address width
- `DATA_W`, 32, write data width
- `KEY_W`, 16, access key width
- `DEPTH`, 4, entries per source FIFO; power of two, at least 2
- `clk`  in  1  single clock, all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `alu_valid`  in  1  ALU write request present
- `alu_ready`  out  1  ALU FIFO can accept this cycle
- `alu_addr`  in  ADDR_W  ALU destination address
- `alu_data`  in  DATA_W  ALU result
- `alu_key`  in  KEY_W  key accompanying the ALU request
- `mem_valid`  in  1  load-result write request present
- `mem_ready`  out  1  memory FIFO can accept this cycle
- `mem_addr`  in  ADDR_W  load destination address
- `mem_data`  in  DATA_W  load data
- `mem_key`  in  KEY_W  key accompanying the load request
- `key_access`  in  KEY_W  expected key, from the register array
- `rf_wen`  out  1  write strobe to the array
- `rf_addr`  out  ADDR_W  write address
- `rf_data`  out  DATA_W  write data
- `drop_cnt`  out  8  count of key-rejected writes, saturating
- `busy`  out  1  either FIFO is non-empty

## Operation
- **Push.** A request is accepted when `valid && ready`; `{addr, data, key}` is written at the FIFO tail.
- **Ready.** `ready = (count != DEPTH)`. It is computed from the registered count only and never depends on `valid` or on a same-cycle pop, so there is no full-FIFO bypass.
- **Arbitration.** Runs each cycle over the two FIFO heads.
  - One head valid: grant it.
  - Both heads valid: grant the source not granted last.
  - `last_grant` updates only on a grant.
- **Pop.** The granted head is popped in the same cycle. Next cycle, `rf_wen = 1` with that entry's addr/data, unless the entry is suppressed.
- **Suppression.** A granted entry is suppressed when either:
  - its addr is 0; it is popped and not counted; or
  - the key check rejects it (see Configuration).
- **Idle.** With no grant, `rf_wen = 0`. `rf_addr` and `rf_data` hold their last value.
- **Ordering.** Per-source FIFO order is preserved. Cross-source order to the same address follows the grant sequence only.
- **Drop counter.** `drop_cnt` increments by 1 per rejected entry and saturates at 255. It does not wrap.
- **Busy.** `busy = |count_alu || |count_mem`, combinational from registered counts.

## Timing
- **Reset values (`rst_n` low):** `rf_wen = 0`, `rf_addr = 0`, `rf_data = 0`, `drop_cnt = 0`, both FIFOs empty, `alu_ready = mem_ready = 1`, `busy = 0`. `last_grant = MEM`, so the first contended grant goes to the ALU.
- **Reset mid-operation:** all queued entries are discarded and no write is issued. Any `rf_wen` already high drops immediately (asynchronous).
- **Latency:** a request accepted into an empty FIFO at edge N produces `rf_wen` high after edge N+1. Uncontended, this is 2 cycles from valid to strobe visible.
- **Throughput:** one write per cycle total. Under continuous contention each source gets every other cycle.
- **Pointers:** wrap modulo `DEPTH`. Count is `log2(DEPTH)+1` bits.
- **Simultaneous push and pop on one FIFO:** count is unchanged. On an empty FIFO, the pushed entry is not granted until the next cycle.

## Configuration
- **Macro:** `WB_KEY_CHECK_EN`.
- **Defined:**
  - Keys are stored in the FIFOs.
  - A granted entry with `key != key_access` is popped and `rf_wen` stays 0.
  - `drop_cnt` increments.
  - The address-0 rule is evaluated first; an address-0 entry is never counted.
- **Undefined:**
  - Keys are not stored, and `alu_key`, `mem_key` and `key_access` are ignored.
  - `drop_cnt` is constant 0.
  - All non-zero-address entries are written.

## Structure
- **Package `wb_pkg`:**
  - `ADDR_W`, `DATA_W` and `KEY_W` default constants.
  - `wb_req_t` struct `{addr, data, key}`; the key field is present only under the macro.
  - `wb_src_e` enum `{SRC_ALU, SRC_MEM}` used for `last_grant`.
- **Sub-module `wb_fifo`:** a synchronous FIFO of `wb_req_t` with count, instantiated twice. The top level holds the arbiter, output registers and drop counter.

## Test plan
- Reset, then ALU push addr 5 / data 0x1234 → `rf_wen` high for one cycle, 2 cycles after valid, with addr 5 / data 0x1234; `busy` returns to 0.
- Both sources push continuously for 8 cycles (ALU addrs 1-8, MEM addrs 11-18) → writes alternate ALU1, MEM11, ALU2, …, with no gap cycles.
- Hold grants off by keeping the other source contending, and push ALU 4 times → `alu_ready` is 0 on the 5th cycle and the 5th request is held. After one pop, `ready` returns and all 5 entries are written in order.
- ALU push to addr 0 → no `rf_wen` and `drop_cnt` unchanged.
- With `WB_KEY_CHECK_EN` and `key_access = 0x0032`: MEM push with key 0x0031 → no write and `drop_cnt = 1`. Then 300 bad-key pushes → `drop_cnt = 255`. A good-key push (0x0032) still writes.
- Assert `rst_n` low with 3 entries queued → `rf_wen` goes to 0 immediately, both `ready` outputs are 1 and nothing is written after release.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types for the writeback arbiter: default widths, the queued request
// record and the source identifier used for round-robin state.
// Optional feature macro: WB_KEY_CHECK_EN (adds the key field to wb_req_t).
package wb_pkg;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned KEY_W  = 16;

  // One queued write; the key travels with the entry only when it is checked.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
`ifdef WB_KEY_CHECK_EN
    logic [KEY_W-1:0]  key;
`endif
  } wb_req_t;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous request FIFO with occupancy count. Ready depends only on the
// registered count, so a full FIFO never accepts even when popped that cycle.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_valid,
  output logic                   push_ready,
  input  wb_req_t                push_req,
  input  logic                   pop,
  output wb_req_t                head,
  output logic                   head_valid,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] CountFull = (PtrW + 1)'(DEPTH);

  wb_req_t         storage [DEPTH];
  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [PtrW:0]   count_q;
  logic [PtrW:0]   count_d;
  logic            do_push;
  logic            do_pop;

  assign push_ready = (count_q != CountFull);
  assign head_valid = (count_q != '0);
  assign do_push    = push_valid && push_ready;
  assign do_pop     = pop && head_valid;
  assign head       = storage[rd_ptr_q];
  assign count      = count_q;

  // Occupancy next state; push and pop together leave it unchanged.
  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointers and count; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Entry storage needs no reset: the count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) storage[wr_ptr_q] <= push_req;
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Round-robin merge of the ALU and load-result write streams into one
// registered write strobe per cycle. Address-0 writes are discarded silently.
// Optional feature macro: WB_KEY_CHECK_EN (drop and count writes whose key
// differs from key_access). Width parameters must match the wb_pkg constants.
module writeback_arbiter
  import wb_pkg::wb_req_t;
  import wb_pkg::wb_src_e;
  import wb_pkg::SRC_ALU;
  import wb_pkg::SRC_MEM;
#(
  parameter int unsigned ADDR_W = wb_pkg::ADDR_W,
  parameter int unsigned DATA_W = wb_pkg::DATA_W,
  parameter int unsigned KEY_W  = wb_pkg::KEY_W,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  input  logic [KEY_W-1:0]  alu_key,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [KEY_W-1:0]  mem_key,
  input  logic [KEY_W-1:0]  key_access,
  output logic              rf_wen,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_data,
  output logic [7:0]        drop_cnt,
  output logic              busy
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  wb_req_t           alu_req;
  wb_req_t           mem_req;
  wb_req_t           alu_head;
  wb_req_t           mem_head;
  wb_req_t           granted;
  logic              alu_head_valid;
  logic              mem_head_valid;
  logic [CntW-1:0]   alu_count;
  logic [CntW-1:0]   mem_count;
  logic              grant_alu;
  logic              grant_mem;
  logic              any_grant;
  logic              addr_zero;
  logic              key_bad;
  logic              write_ok;
  wb_src_e           last_grant_q;
  logic              rf_wen_q;
  logic [ADDR_W-1:0] rf_addr_q;
  logic [DATA_W-1:0] rf_data_q;

  // Pack incoming requests into FIFO records.
  always_comb begin
    alu_req      = '0;
    alu_req.addr = alu_addr;
    alu_req.data = alu_data;
    mem_req      = '0;
    mem_req.addr = mem_addr;
    mem_req.data = mem_data;
`ifdef WB_KEY_CHECK_EN
    alu_req.key  = alu_key;
    mem_req.key  = mem_key;
`endif
  end

  wb_fifo #(
    .DEPTH(DEPTH)
  ) u_alu_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_valid(alu_valid),
    .push_ready(alu_ready),
    .push_req  (alu_req),
    .pop       (grant_alu),
    .head      (alu_head),
    .head_valid(alu_head_valid),
    .count     (alu_count)
  );

  wb_fifo #(
    .DEPTH(DEPTH)
  ) u_mem_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_valid(mem_valid),
    .push_ready(mem_ready),
    .push_req  (mem_req),
    .pop       (grant_mem),
    .head      (mem_head),
    .head_valid(mem_head_valid),
    .count     (mem_count)
  );

  // Round-robin grant: on contention the source not granted last wins.
  always_comb begin
    grant_alu = 1'b0;
    grant_mem = 1'b0;
    if (alu_head_valid && mem_head_valid) begin
      if (last_grant_q == SRC_MEM) grant_alu = 1'b1;
      else                         grant_mem = 1'b1;
    end else if (alu_head_valid) begin
      grant_alu = 1'b1;
    end else if (mem_head_valid) begin
      grant_mem = 1'b1;
    end
  end

  assign any_grant = grant_alu || grant_mem;
  assign granted   = grant_alu ? alu_head : mem_head;

  // Suppression: address 0 takes precedence and is never counted as a drop.
  always_comb begin
    addr_zero = (granted.addr == '0);
    key_bad   = 1'b0;
`ifdef WB_KEY_CHECK_EN
    key_bad   = (granted.key != key_access);
`endif
    write_ok  = any_grant && !addr_zero && !key_bad;
  end

  // Registered write strobe; address and data hold when nothing is written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_wen_q     <= 1'b0;
      rf_addr_q    <= '0;
      rf_data_q    <= '0;
      last_grant_q <= SRC_MEM;
    end else begin
      rf_wen_q <= write_ok;
      if (write_ok) begin
        rf_addr_q <= granted.addr;
        rf_data_q <= granted.data;
      end
      if (any_grant) last_grant_q <= grant_alu ? SRC_ALU : SRC_MEM;
    end
  end

`ifdef WB_KEY_CHECK_EN
  logic [7:0] drop_cnt_q;
  logic       drop_hit;

  assign drop_hit = any_grant && !addr_zero && key_bad;

  // Saturating count of key-rejected writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q <= '0;
    end else if (drop_hit && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_q <= drop_cnt_q + 1'b1;
    end
  end

  assign drop_cnt = drop_cnt_q;
`else
  // Keys are ignored when the check is compiled out.
  logic unused_keys;
  assign unused_keys = ^{alu_key, mem_key, key_access, key_bad};
  assign drop_cnt    = 8'd0;
`endif

  assign rf_wen  = rf_wen_q;
  assign rf_addr = rf_addr_q;
  assign rf_data = rf_data_q;
  assign busy    = (|alu_count) || (|mem_count);

endmodule

// File: tb/tb_writeback_arbiter.sv
// Scoreboard bench for writeback_arbiter: stimulus queues hand-computed
// expected writes, a negedge monitor pops and compares every rf_wen strobe.
module tb_writeback_arbiter;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned KEY_W  = 16;
  localparam int unsigned DEPTH  = 4;
  localparam logic [KEY_W-1:0] KeyGood = 16'h0032;
  localparam logic [KEY_W-1:0] KeyBad  = 16'h0031;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              alu_valid = 1'b0;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_addr = '0;
  logic [DATA_W-1:0] alu_data = '0;
  logic [KEY_W-1:0]  alu_key = '0;
  logic              mem_valid = 1'b0;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr = '0;
  logic [DATA_W-1:0] mem_data = '0;
  logic [KEY_W-1:0]  mem_key = '0;
  logic [KEY_W-1:0]  key_access = KeyGood;
  logic              rf_wen;
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rf_data;
  logic [7:0]        drop_cnt;
  logic              busy;

  always #5 clk = ~clk;

  writeback_arbiter #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .KEY_W (KEY_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_addr  (alu_addr),
    .alu_data  (alu_data),
    .alu_key   (alu_key),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .mem_key   (mem_key),
    .key_access(key_access),
    .rf_wen    (rf_wen),
    .rf_addr   (rf_addr),
    .rf_data   (rf_data),
    .drop_cnt  (drop_cnt),
    .busy      (busy)
  );

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_fails = 0;
  int  cyc = 0;
  int  wr_cnt = 0;
  int  first_wr_cyc = -1;
  int  last_wr_cyc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every strobe must match the oldest expected write.
  always @(negedge clk) begin
    wr_t e;
    if (rf_wen) begin
      wr_cnt++;
      if (first_wr_cyc < 0) first_wr_cyc = cyc;
      last_wr_cyc = cyc;
      n_checks++;
      if (!rst_n) begin
        n_fails++;
        $display("FAIL wr_in_reset: rf_wen=1 addr=%0d, required rf_wen=0", rf_addr);
      end else if (exp_q.size() == 0) begin
        n_fails++;
        $display("FAIL unexpected_write: addr=%0d data=%h, required no write", rf_addr, rf_data);
      end else begin
        e = exp_q.pop_front();
        if (rf_addr !== e.addr || rf_data !== e.data) begin
          n_fails++;
          $display("FAIL write_order: got addr=%0d data=%h, required addr=%0d data=%h",
                   rf_addr, rf_data, e.addr, e.data);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic expect_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  // Hold valid until the FIFO accepts; stalls counts cycles spent not ready.
  task automatic alu_push(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                          input logic [KEY_W-1:0] k, output int stalls);
    alu_valid = 1'b1;
    alu_addr  = a;
    alu_data  = d;
    alu_key   = k;
    stalls    = 0;
    while (!alu_ready && stalls < 50) begin
      tick(1);
      stalls++;
    end
    if (!alu_ready) begin
      n_checks++;
      n_fails++;
      $display("FAIL alu_push_timeout: alu_ready=0 for %0d cycles, required 1", stalls);
    end else begin
      tick(1);
    end
    alu_valid = 1'b0;
  endtask

  task automatic mem_push(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                          input logic [KEY_W-1:0] k, output int stalls);
    mem_valid = 1'b1;
    mem_addr  = a;
    mem_data  = d;
    mem_key   = k;
    stalls    = 0;
    while (!mem_ready && stalls < 50) begin
      tick(1);
      stalls++;
    end
    if (!mem_ready) begin
      n_checks++;
      n_fails++;
      $display("FAIL mem_push_timeout: mem_ready=0 for %0d cycles, required 1", stalls);
    end else begin
      tick(1);
    end
    mem_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    int c0;
    int base;
    int alu_stalls;

    // Reset state, sampled asynchronously while rst_n is low.
    #2;
    check("rst_rf_wen", rf_wen, 0);
    check("rst_rf_addr", rf_addr, 0);
    check("rst_rf_data", rf_data, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    check("rst_alu_ready", alu_ready, 1);
    check("rst_mem_ready", mem_ready, 1);
    check("rst_busy", busy, 0);
    tick(2);
    rst_n = 1'b1;
    tick(1);

    // Single uncontended write: strobe visible two cycles after valid.
    base = wr_cnt;
    first_wr_cyc = -1;
    c0 = cyc;
    expect_wr(10'd5, 32'h1234);
    alu_push(10'd5, 32'h1234, KeyGood, st);
    tick(4);
    check("single_latency", last_wr_cyc - c0, 2);
    check("single_count", wr_cnt - base, 1);
    check("single_busy", busy, 0);
    check("single_wen_low", rf_wen, 0);
    check("single_addr_hold", rf_addr, 5);
    check("single_data_hold", rf_data, 32'h1234);

    // Continuous contention: strict alternation starting with the ALU, no gaps,
    // and the ALU FIFO fills so its 8th request is held.
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      expect_wr(ADDR_W'(i), 32'hA000 + i);
      expect_wr(ADDR_W'(10 + i), 32'hB000 + i);
    end
    base = wr_cnt;
    first_wr_cyc = -1;
    alu_stalls = 0;
    fork
      begin
        int s;
        for (int i = 1; i <= 8; i++) begin
          alu_push(ADDR_W'(i), 32'hA000 + i, KeyGood, s);
          alu_stalls += s;
        end
      end
      begin
        int s;
        for (int j = 1; j <= 8; j++) mem_push(ADDR_W'(10 + j), 32'hB000 + j, KeyGood, s);
      end
    join
    tick(12);
    check("rr_count", wr_cnt - base, 16);
    check("rr_no_gaps", last_wr_cyc - first_wr_cyc, 15);
    check("rr_alu_full_stall", (alu_stalls > 0) ? 1 : 0, 1);
    check("rr_queue_drained", exp_q.size(), 0);
    check("rr_busy", busy, 0);
    check("rr_last_addr", rf_addr, 18);

    // Address 0 is discarded and never counted, whatever its key.
    base = wr_cnt;
    alu_push(10'd0, 32'hDEAD, KeyGood, st);
    mem_push(10'd0, 32'hBEEF, KeyBad, st);
    tick(4);
    check("addr0_no_write", wr_cnt - base, 0);
    check("addr0_drop_cnt", drop_cnt, 0);
    check("addr0_busy", busy, 0);

`ifdef WB_KEY_CHECK_EN
    // Key check: bad keys are dropped and counted, saturating at 255.
    base = wr_cnt;
    mem_push(10'd20, 32'h2020, KeyBad, st);
    tick(3);
    check("key_first_drop", drop_cnt, 1);
    check("key_no_write", wr_cnt - base, 0);
    for (int i = 0; i < 253; i++) mem_push(10'd20 + 10'(i % 7), 32'h3000 + i, KeyBad, st);
    tick(3);
    check("key_drop_254", drop_cnt, 254);
    for (int i = 0; i < 47; i++) mem_push(10'd30, 32'h4000 + i, KeyBad, st);
    tick(3);
    check("key_drop_sat", drop_cnt, 255);
    expect_wr(10'd21, 32'h5555);
    mem_push(10'd21, 32'h5555, KeyGood, st);
    tick(3);
    check("key_good_write", wr_cnt - base, 1);
    check("key_drop_hold", drop_cnt, 255);
`else
    // Without the key check, keys are ignored and nothing is ever dropped.
    base = wr_cnt;
    for (int i = 0; i < 5; i++) begin
      expect_wr(10'd20 + 10'(i), 32'h2020 + i);
      mem_push(10'd20 + 10'(i), 32'h2020 + i, KeyBad, st);
    end
    tick(3);
    check("nokey_writes", wr_cnt - base, 5);
    check("nokey_drop_cnt", drop_cnt, 0);
`endif
    check("key_queue_drained", exp_q.size(), 0);

    // Reset with entries queued and a strobe in flight.
    do_reset();
    expect_wr(10'd31, 32'hC001);
    alu_valid = 1'b1;
    alu_addr  = 10'd31;
    alu_data  = 32'hC001;
    alu_key   = KeyGood;
    mem_valid = 1'b1;
    mem_addr  = 10'd41;
    mem_data  = 32'hD001;
    mem_key   = KeyGood;
    tick(1);
    alu_addr  = 10'd32;
    alu_data  = 32'hC002;
    mem_addr  = 10'd42;
    mem_data  = 32'hD002;
    tick(1);
    alu_addr  = 10'd33;
    alu_data  = 32'hC003;
    mem_addr  = 10'd43;
    mem_data  = 32'hD003;
    tick(1);
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    check("pre_reset_wen", rf_wen, 1);
    check("pre_reset_addr", rf_addr, 41);
    check("pre_reset_busy", busy, 1);
    #1;
    rst_n = 1'b0;
    base = wr_cnt;
    #1;
    check("mid_reset_wen", rf_wen, 0);
    check("mid_reset_alu_ready", alu_ready, 1);
    check("mid_reset_mem_ready", mem_ready, 1);
    check("mid_reset_busy", busy, 0);
    check("mid_reset_addr", rf_addr, 0);
    tick(2);
    rst_n = 1'b1;
    tick(6);
    check("post_reset_no_write", wr_cnt - base, 0);
    check("post_reset_busy", busy, 0);
    check("final_queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
